// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared extension-mode encoding and default widths for the
//               immediate extension unit and the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

  // Encoding is shared with the decoder, so the numeric values are fixed.
  typedef enum logic [1:0] {
    IMM_SEXT   = 2'd0,
    IMM_ZEXT   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  localparam int DEF_IN_W     = 16;
  localparam int DEF_OUT_W    = 32;
  localparam int DEF_BR_SHIFT = 2;
  localparam int DEF_TAG_W    = 5;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extension datapath (sign, zero,
//               upper-placed and shifted branch-offset forms).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int BR_SHIFT = DEF_BR_SHIFT
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] ext
);

  localparam int FILL_W = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;

  assign w_sext   = {{FILL_W{imm[IN_W-1]}}, imm};
  assign w_zext   = {{FILL_W{1'b0}}, imm};
  assign w_upper  = {imm, {FILL_W{1'b0}}};
  // Bits pushed past the MSB are simply dropped by the fixed-width shift.
  assign w_branch = w_sext << BR_SHIFT;

  always_comb begin
    ext = w_sext;
    case (mode)
      IMM_SEXT:   ext = w_sext;
      IMM_ZEXT:   ext = w_zext;
      IMM_UPPER:  ext = w_upper;
      IMM_BRANCH: ext = w_branch;
      default:    ext = w_sext;
    endcase
  end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_unit
// Description : Immediate extension unit with valid/ready handshake and a
//               2-entry output buffer. Optional sideband tag enabled by the
//               IMM_EXT_TAG_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int BR_SHIFT = DEF_BR_SHIFT,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
`ifdef IMM_EXT_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
`ifdef IMM_EXT_TAG_EN
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic [OUT_W-1:0] out_imm
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  if ((IN_W < 2) || (IN_W >= OUT_W)) begin : g_bad_in_w
    $error("imm_extend_unit: IN_W must be in 2..OUT_W-1");
  end
  if ((BR_SHIFT < 0) || (BR_SHIFT > OUT_W - IN_W)) begin : g_bad_br_shift
    $error("imm_extend_unit: BR_SHIFT must be in 0..OUT_W-IN_W");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("imm_extend_unit: TAG_W must be at least 1");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_slot0;
  logic [OUT_W-1:0] r_slot1;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;
  logic             w_wr0;
  logic             w_wr0_from_in;
  logic             w_wr1;

  imm_ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .imm  (in_imm),
    .mode (imm_mode_e'(in_mode)),
    .ext  (w_ext)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_imm   = r_slot0;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;

  // Slot 0 is always the oldest entry; slot 1 only fills while slot 0 is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr0         = 1'b0;
    w_wr0_from_in = 1'b1;
    w_wr1         = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_wr0       = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && w_pop) begin
          w_wr0 = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_TWO;
          w_wr1       = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt   = ST_ONE;
          w_wr0         = 1'b1;
          w_wr0_from_in = 1'b0;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered from next state so out_ready never reaches in_ready combinationally.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      if (w_wr0) begin
        r_slot0 <= w_wr0_from_in ? w_ext : r_slot1;
      end
      if (w_wr1) begin
        r_slot1 <= w_ext;
      end
    end
  end

`ifdef IMM_EXT_TAG_EN
  logic [TAG_W-1:0] r_tag0;
  logic [TAG_W-1:0] r_tag1;

  assign out_tag = r_tag0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag0 <= '0;
      r_tag1 <= '0;
    end else begin
      if (w_wr0) begin
        r_tag0 <= w_wr0_from_in ? in_tag : r_tag1;
      end
      if (w_wr1) begin
        r_tag1 <= in_tag;
      end
    end
  end
`endif

endmodule : imm_extend_unit
`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_unit
// Description : Directed self-checking bench for imm_extend_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
`ifdef IMM_EXT_TAG_EN
  logic [4:0]  in_tag;
  logic [4:0]  out_tag;
`endif

  int total;
  int bad;

  imm_extend_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
`ifdef IMM_EXT_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: branch offset as sign-extended value times 4.
  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] v);
    logic [31:0] s;
    s = {{16{v[15]}}, v};
    case (m)
      2'd0:    return s;
      2'd1:    return {16'h0000, v};
      2'd2:    return {v, 16'h0000};
      default: return s * 32'd4;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
    end
    tick;
    tick;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_ready: in_ready=%b required 0", in_ready);
    end
    rst_n = 1'b1;
    tick;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_modes;
    logic [1:0]  modes [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2};
    logic [15:0] imms  [8] = '{16'h8001, 16'h7FFF, 16'h8001, 16'h1234,
                               16'hFFFF, 16'h0004, 16'hFFFF, 16'h8001};
    logic [31:0] exps  [8] = '{32'hFFFF8001, 32'h00007FFF, 32'h00008001, 32'h12340000,
                               32'hFFFFFFFC, 32'h00000010, 32'h0000FFFF, 32'h80010000};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = modes[i];
      in_imm   = imms[i];
      tick;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_imm !== exps[i]) begin
        bad++;
        $display("FAIL mode_vec%0d: out_valid=%b out_imm=%h required 1/%h", i, out_valid, out_imm, exps[i]);
      end
      tick;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mode_drain%0d: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 16'h0001;
    tick;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== 32'h00000001) begin
      bad++;
      $display("FAIL bp_first: v=%b rdy=%b imm=%h required 1/1/00000001", out_valid, in_ready, out_imm);
    end
    in_imm = 16'h8002;
    tick;
    total++;
    if (in_ready !== 1'b0 || out_imm !== 32'h00000001) begin
      bad++;
      $display("FAIL bp_full: rdy=%b imm=%h required 0/00000001", in_ready, out_imm);
    end
    in_mode = 2'd1;
    in_imm  = 16'h0003;
    tick;
    tick;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h00000001) begin
      bad++;
      $display("FAIL bp_hold: rdy=%b v=%b imm=%h required 0/1/00000001", in_ready, out_valid, out_imm);
    end
    out_ready = 1'b1;
    tick;
    total++;
    if (out_imm !== 32'hFFFF8002 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_second: imm=%h rdy=%b v=%b required FFFF8002/1/1", out_imm, in_ready, out_valid);
    end
    tick;
    in_valid = 1'b0;
    total++;
    if (out_imm !== 32'h00000003 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_third: imm=%h v=%b required 00000003/1", out_imm, out_valid);
    end
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'($urandom_range(0, 3));
      in_imm   = 16'($urandom);
      exp      = ref_ext(in_mode, in_imm);
      tick;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== exp) begin
        bad++;
        $display("FAIL stream%0d: v=%b rdy=%b imm=%h required 1/1/%h", i, out_valid, in_ready, out_imm, exp);
      end
    end
    in_valid = 1'b0;
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_imm    = 16'h5A5A;
    tick;
    in_imm    = 16'hA5A5;
    tick;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_full: v=%b rdy=%b required 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_imm !== 32'h0) begin
      bad++;
      $display("FAIL rmid_async: v=%b rdy=%b imm=%h required 0/0/00000000", out_valid, in_ready, out_imm);
    end
    tick;
    rst_n = 1'b1;
    tick;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_release: rdy=%b v=%b required 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rmid_stale%0d: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

`ifdef IMM_EXT_TAG_EN
  task automatic test_tags;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 16'h0011;
    in_tag    = 5'h03;
    tick;
    in_imm    = 16'h0022;
    in_tag    = 5'h1F;
    tick;
    in_valid  = 1'b0;
    tick;
    total++;
    if (out_tag !== 5'h03 || out_imm !== 32'h00000011) begin
      bad++;
      $display("FAIL tag_first: tag=%h imm=%h required 03/00000011", out_tag, out_imm);
    end
    out_ready = 1'b1;
    tick;
    total++;
    if (out_tag !== 5'h1F || out_imm !== 32'h00000022) begin
      bad++;
      $display("FAIL tag_second: tag=%h imm=%h required 1f/00000022", out_tag, out_imm);
    end
    tick;
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
`ifdef IMM_EXT_TAG_EN
    in_tag    = '0;
`endif
    test_reset;
    test_modes;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
`ifdef IMM_EXT_TAG_EN
    test_tags;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imm_extend_unit
`default_nettype wire

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width (2..OUT_W-1).
REQ-002 SHALL have parameter OUT_W, default 32, extended output width.
REQ-003 SHALL have parameter BR_SHIFT, default 2, left-shift amount for branch-offset mode (0..OUT_W-IN_W).
REQ-004 SHALL have parameter TAG_W, default 5, sideband tag width (used only with IMM_EXT_TAG_EN).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  source presents an immediate.
REQ-008 SHALL have port in_ready  output  1  unit accepts input this cycle.
REQ-009 SHALL have port in_imm  input  IN_W  raw immediate field.
REQ-010 SHALL have port in_mode  input  2  extension mode, from the shared package encoding.
REQ-011 SHALL have port in_tag  input  TAG_W  sideband tag (only with IMM_EXT_TAG_EN).
REQ-012 SHALL have port out_valid  output  1  extended result available.
REQ-013 SHALL have port out_ready  input  1  sink accepts result this cycle.
REQ-014 SHALL have port out_imm  output  OUT_W  extended immediate.
REQ-015 SHALL have port out_tag  output  TAG_W  tag accompanying out_imm (only with IMM_EXT_TAG_EN).

Function
REQ-016 SHALL transfer input when in_valid and in_ready are both high at a clk edge; output transfers when out_valid and out_ready are both high.
REQ-017 SHALL apply mode SEXT (0): out = in_imm replicated MSB into bits OUT_W-1..IN_W.
REQ-018 SHALL apply mode ZEXT (1): out = in_imm with upper bits zero.
REQ-019 SHALL apply mode UPPER (2): out[OUT_W-1:OUT_W-IN_W] = in_imm, remaining low bits zero.
REQ-020 SHALL apply mode BRANCH (3): sign-extend, then shift left by BR_SHIFT with zeros shifted in; bits shifted past OUT_W-1 are discarded.
REQ-021 SHALL compute the result at input acceptance and store it in a 2-entry FIFO buffer; latency from accepted input to out_valid is exactly 1 cycle when the buffer is empty.
REQ-022 SHALL use buffer-occupancy states EMPTY, ONE, TWO; push only: EMPTY->ONE, ONE->TWO; pop only: TWO->ONE, ONE->EMPTY; push and pop in ONE: stays ONE.
REQ-023 SHALL drive in_ready from a register: high in EMPTY and ONE, low in TWO; no combinational path from out_ready to in_ready.
REQ-024 SHALL drive out_valid high in ONE and TWO, low in EMPTY; out_imm/out_tag always show the oldest entry and SHALL hold stable while out_valid high and out_ready low.
REQ-025 SHALL preserve strict in-order delivery; no entry dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 SHALL treat out_imm as don't-care while out_valid low.

Reset
REQ-027 SHALL on rst_n low, asynchronously: state EMPTY, out_valid 0, in_ready 0, buffer data cleared to 0.
REQ-028 SHALL raise in_ready on the first clk edge after rst_n deasserts; entries held at a reset mid-operation are discarded.

Configuration
REQ-029 SHALL, with macro IMM_EXT_TAG_EN defined, include in_tag/out_tag ports and store each tag alongside its immediate with identical ordering and latency.
REQ-030 SHALL, without IMM_EXT_TAG_EN, omit in_tag/out_tag and all tag storage; all other behaviour identical.

Structure
REQ-031 SHALL place the 2-bit mode enumeration (SEXT, ZEXT, UPPER, BRANCH) and default width constants in shared package imm_ext_pkg, reused by the decoder.
REQ-032 SHALL implement the combinational extension datapath as sub-module imm_ext_core (inputs imm, mode; output extended value); buffering and handshake stay in imm_extend_unit.

Verification
REQ-033 SHALL cover SEXT 0x8001 and 0x7FFF -> out_imm 0xFFFF8001 and 0x00007FFF, one cycle after acceptance.
REQ-034 SHALL cover ZEXT 0x8001 -> 0x00008001; UPPER 0x1234 -> 0x12340000; BRANCH 0xFFFF -> 0xFFFFFFFC, 0x0004 -> 0x00000010.
REQ-035 SHALL cover out_ready held low, 3 back-to-back inputs -> first two accepted, in_ready low from the cycle after the second, third held; release out_ready -> results in order.
REQ-036 SHALL cover continuous in_valid and out_ready high for 100 random transfers -> one result per cycle, state stays ONE, results match a reference model in order.
REQ-037 SHALL cover rst_n pulsed low while state TWO -> out_valid 0 immediately, in_ready 1 after first post-reset edge, no stale result emitted.
REQ-038 SHALL cover IMM_EXT_TAG_EN build with tags 0x03, 0x1F under backpressure -> out_tag matches the tag of each out_imm.
